// File: rtl/time_entry_pkg.sv
// Shared definitions for the BCD time-entry block.
//   - FSM state encoding (S_IDLE / S_EDIT / S_COMMIT)
//   - per-digit limits for MM:SS BCD digits
//   - one-hot cursor constants (CUR_MM_T selects value[15:12])
//   - digit_limit(): limit of digit index 0..3 (0 = seconds units)
package time_entry_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EDIT   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  localparam logic [3:0] TENS_MAX  = 4'd5;
  localparam logic [3:0] UNITS_MAX = 4'd9;

  localparam logic [3:0] CUR_MM_T = 4'b1000;
  localparam logic [3:0] CUR_MM_U = 4'b0100;
  localparam logic [3:0] CUR_SS_T = 4'b0010;
  localparam logic [3:0] CUR_SS_U = 4'b0001;

  // Odd digit indices (1 = sec tens, 3 = min tens) are tens digits.
  function automatic logic [3:0] digit_limit(input int idx);
    return (idx % 2 == 1) ? TENS_MAX : UNITS_MAX;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, debounce counter, rising-edge detect.
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous, active-high reset (level returns to released)
//   raw    in  raw asynchronous button input
//   level  out debounced button level
//   press  out one-cycle pulse when level rises
// The counter tracks consecutive synchronised samples that differ from the
// stable level; any sample equal to the stable level restarts it.
module btn_debounce #(
  parameter logic [19:0] DB_CYCLES = 20'd50000,
  parameter int          DB_W      = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 20'd1);

  logic            sync1_reg;
  logic            sync2_reg;
  logic [DB_W-1:0] cnt_reg;
  logic            level_reg;
  logic            press_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      cnt_reg   <= '0;
      level_reg <= 1'b0;
      press_reg <= 1'b0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      press_reg <= 1'b0;
      if (sync2_reg == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == DB_LAST) begin
        // DB_CYCLES-th differing sample: accept the new level
        cnt_reg   <= '0;
        level_reg <= sync2_reg;
        press_reg <= sync2_reg;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign level = level_reg;
  assign press = press_reg;

endmodule

// File: rtl/bcd_time_entry.sv
// Five-button editor for a 4-digit BCD MM:SS value.
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   enable              mode switch; rising edge starts an edit, low aborts
//   btn_up/down/left/right/center   raw push buttons (center = commit)
//   load_value[15:0]    value captured (with invalid digits cleared) on edit start
//   value[15:0]         value being edited
//   cursor[3:0]         one-hot selected digit, 4'b1000 = value[15:12]
//   editing             high while in EDIT
//   finish              one-cycle commit pulse, value valid in that cycle
// Optional feature: define TIME_ENTRY_AUTOREPEAT_EN to auto-repeat up/down
// every RPT_CYCLES while the button stays held in EDIT.
module bcd_time_entry
  import time_entry_pkg::*;
#(
  parameter logic [19:0] DB_CYCLES  = 20'd50000,
  parameter int          DB_W       = 20
`ifdef TIME_ENTRY_AUTOREPEAT_EN
  ,
  parameter logic [23:0] RPT_CYCLES = 24'd5000000
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_center,
  input  logic [15:0] load_value,
  output logic [15:0] value,
  output logic [3:0]  cursor,
  output logic        editing,
  output logic        finish
);

  // Button index map: 0 right, 1 left, 2 down, 3 up, 4 center
  logic [4:0] raw_vec;
  logic [4:0] level_vec;
  logic [4:0] press_vec;

  assign raw_vec = {btn_center, btn_up, btn_down, btn_left, btn_right};

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_btn
      btn_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db (
        .clk   (clk),
        .reset (reset),
        .raw   (raw_vec[gi]),
        .level (level_vec[gi]),
        .press (press_vec[gi])
      );
    end
  endgenerate

  state_t      state_reg;
  logic [15:0] value_reg;
  logic [3:0]  cursor_reg;
  logic        editing_reg;
  logic        finish_reg;
  logic        enable_d_reg;

  logic up_evt;
  logic down_evt;

`ifdef TIME_ENTRY_AUTOREPEAT_EN
  localparam logic [23:0] RPT_LAST = RPT_CYCLES - 24'd1;
  logic [23:0] rpt_cnt_reg;
  logic        rpt_step;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rpt_cnt_reg <= '0;
    end else if (state_reg == S_EDIT && (level_vec[3] || level_vec[2])) begin
      rpt_cnt_reg <= (rpt_cnt_reg == RPT_LAST) ? 24'd0 : rpt_cnt_reg + 24'd1;
    end else begin
      rpt_cnt_reg <= '0;
    end
  end

  assign rpt_step = (rpt_cnt_reg == RPT_LAST);
  assign up_evt   = press_vec[3] | (rpt_step & level_vec[3]);
  assign down_evt = press_vec[2] | (rpt_step & level_vec[2]);
`else
  assign up_evt   = press_vec[3];
  assign down_evt = press_vec[2];
`endif

  // Levels are only consumed by the auto-repeat logic.
  logic unused_levels;
  assign unused_levels = ^level_vec;

  // Per-digit incremented, decremented and sanitised candidates.
  logic [15:0] value_up;
  logic [15:0] value_dn;
  logic [15:0] load_clean;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      localparam logic [3:0] LIM = digit_limit(gi);
      logic [3:0] d;
      logic [3:0] l;
      assign d = value_reg[4*gi +: 4];
      assign l = load_value[4*gi +: 4];
      assign value_up[4*gi +: 4]   = !cursor_reg[gi] ? d : ((d >= LIM) ? 4'd0 : d + 4'd1);
      assign value_dn[4*gi +: 4]   = !cursor_reg[gi] ? d : ((d == 4'd0) ? LIM : d - 4'd1);
      assign load_clean[4*gi +: 4] = (l > LIM) ? 4'd0 : l;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      value_reg    <= 16'h0000;
      cursor_reg   <= CUR_MM_T;
      editing_reg  <= 1'b0;
      finish_reg   <= 1'b0;
      enable_d_reg <= 1'b0;
    end else begin
      enable_d_reg <= enable;
      finish_reg   <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          editing_reg <= 1'b0;
          if (enable && !enable_d_reg) begin
            state_reg   <= S_EDIT;
            editing_reg <= 1'b1;
            value_reg   <= load_clean;
            cursor_reg  <= CUR_MM_T;
          end
        end
        S_EDIT: begin
          if (!enable) begin
            state_reg   <= S_IDLE;
            editing_reg <= 1'b0;
          end else if (press_vec[4]) begin
            state_reg   <= S_COMMIT;
            editing_reg <= 1'b0;
            finish_reg  <= 1'b1;
          end else if (up_evt) begin
            value_reg <= value_up;
          end else if (down_evt) begin
            value_reg <= value_dn;
          end else if (press_vec[1]) begin
            cursor_reg <= {cursor_reg[2:0], cursor_reg[3]};
          end else if (press_vec[0]) begin
            cursor_reg <= {cursor_reg[0], cursor_reg[3:1]};
          end
        end
        S_COMMIT: begin
          // enable_d_reg is updated here too, so an edge in this cycle is consumed
          state_reg   <= S_IDLE;
          editing_reg <= 1'b0;
        end
        default: begin
          state_reg   <= S_IDLE;
          editing_reg <= 1'b0;
        end
      endcase
    end
  end

  assign value   = value_reg;
  assign cursor  = cursor_reg;
  assign editing = editing_reg;
  assign finish  = finish_reg;

endmodule

// File: tb/tb_bcd_time_entry.sv
// Directed self-checking bench for bcd_time_entry with DB_CYCLES=4.
module tb_bcd_time_entry;

  localparam logic [4:0] B_RIGHT  = 5'b00001;
  localparam logic [4:0] B_LEFT   = 5'b00010;
  localparam logic [4:0] B_DOWN   = 5'b00100;
  localparam logic [4:0] B_UP     = 5'b01000;
  localparam logic [4:0] B_CENTER = 5'b10000;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [4:0]  btn;
  logic [15:0] load_value;
  logic [15:0] value;
  logic [3:0]  cursor;
  logic        editing;
  logic        finish;

  int checks = 0;
  int errors = 0;
  int fin_cnt = 0;
  logic [15:0] fin_value;
  logic        fin_editing;

  always #5 clk = ~clk;

  bcd_time_entry #(.DB_CYCLES(20'd4), .DB_W(20)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .btn_up     (btn[3]),
    .btn_down   (btn[2]),
    .btn_left   (btn[1]),
    .btn_right  (btn[0]),
    .btn_center (btn[4]),
    .load_value (load_value),
    .value      (value),
    .cursor     (cursor),
    .editing    (editing),
    .finish     (finish)
  );

  // Advance n cycles, sampling on negedge and recording finish pulses.
  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      if (finish) begin
        fin_cnt++;
        fin_value   = value;
        fin_editing = editing;
      end
    end
  endtask

  task automatic press(input logic [4:0] mask);
    btn = mask;
    wait_cycles(10);
    btn = 5'b0;
    wait_cycles(10);
  endtask

  task automatic start_edit(input logic [15:0] lv);
    enable = 1'b0;
    load_value = lv;
    wait_cycles(2);
    enable = 1'b1;
    wait_cycles(2);
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else $display("ok   %s: %h", name, act);
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 1'b0; btn = 5'b0; load_value = 16'h0;
    wait_cycles(3);
    checks++; if (value !== 16'h0000) begin errors++; $display("FAIL reset_value: got %h expected 0000", value); end
    checks++; if (cursor !== 4'b1000) begin errors++; $display("FAIL reset_cursor: got %b expected 1000", cursor); end
    checks++; if (editing !== 1'b0) begin errors++; $display("FAIL reset_editing: got %b expected 0", editing); end
    checks++; if (finish !== 1'b0) begin errors++; $display("FAIL reset_finish: got %b expected 0", finish); end
    $display("reset checked");
    reset = 1'b0;
    wait_cycles(2);
  endtask

  task automatic test_load_up;
    start_edit(16'h5959);
    chk16("load_5959", value, 16'h5959);
    checks++; if (editing !== 1'b1) begin errors++; $display("FAIL edit_entry: got %b expected 1", editing); end
    press(B_UP);
    chk16("up_wrap_tens", value, 16'h0959);
    checks++; if (cursor !== 4'b1000) begin errors++; $display("FAIL up_cursor: got %b expected 1000", cursor); end
  endtask

  task automatic test_invalid_load;
    enable = 1'b0;
    wait_cycles(3);
    checks++; if (editing !== 1'b0) begin errors++; $display("FAIL abort_editing: got %b expected 0", editing); end
    chk16("abort_retain", value, 16'h0959);
    start_edit(16'h7A00);
    chk16("load_invalid", value, 16'h0000);
  endtask

  task automatic test_cursor_down;
    press(B_RIGHT); press(B_RIGHT); press(B_RIGHT);
    checks++; if (cursor !== 4'b0001) begin errors++; $display("FAIL right_x3: got %b expected 0001", cursor); end
    press(B_DOWN);
    chk16("down_wrap_units", value, 16'h0009);
    press(B_DOWN);
    chk16("down_units", value, 16'h0008);
  endtask

  task automatic test_bouncy;
    for (int i = 0; i < 5; i++) begin
      btn = (i % 2 == 0) ? B_UP : 5'b0;
      wait_cycles(2);
    end
    btn = B_UP;
    wait_cycles(10);
    btn = 5'b0;
    wait_cycles(10);
    chk16("bouncy_single", value, 16'h0009);
  endtask

  task automatic test_commit;
    fin_cnt = 0;
    press(B_CENTER);
    checks++; if (fin_cnt !== 1) begin errors++; $display("FAIL commit_pulses: got %0d expected 1", fin_cnt); end
    chk16("commit_value", fin_value, 16'h0009);
    checks++; if (fin_editing !== 1'b0) begin errors++; $display("FAIL commit_editing: got %b expected 0", fin_editing); end
    checks++; if (editing !== 1'b0) begin errors++; $display("FAIL post_commit_editing: got %b expected 0", editing); end
  endtask

  task automatic test_abort;
    start_edit(16'h1234);
    chk16("load_1234", value, 16'h1234);
    fin_cnt = 0;
    btn = B_DOWN;
    wait_cycles(3);
    enable = 1'b0;
    wait_cycles(10);
    btn = 5'b0;
    wait_cycles(10);
    checks++; if (fin_cnt !== 0) begin errors++; $display("FAIL abort_finish: got %0d expected 0", fin_cnt); end
    checks++; if (editing !== 1'b0) begin errors++; $display("FAIL abort2_editing: got %b expected 0", editing); end
    chk16("abort_value", value, 16'h1234);
  endtask

  task automatic test_up_left;
    start_edit(16'h1234);
    press(B_UP | B_LEFT);
    chk16("priority_up", value, 16'h2234);
    checks++; if (cursor !== 4'b1000) begin errors++; $display("FAIL priority_cursor: got %b expected 1000", cursor); end
  endtask

  task automatic test_wrap;
    start_edit(16'h0000);
    press(B_DOWN);
    chk16("down_wrap_tens", value, 16'h5000);
    press(B_LEFT);
    checks++; if (cursor !== 4'b0001) begin errors++; $display("FAIL left_rotate: got %b expected 0001", cursor); end
    press(B_UP);
    chk16("up_units", value, 16'h5001);
  endtask

  task automatic test_reset_mid;
    start_edit(16'h1234);
    btn = B_UP;
    wait_cycles(4);
    reset = 1'b1;
    enable = 1'b0;
    wait_cycles(2);
    chk16("midreset_value", value, 16'h0000);
    checks++; if (cursor !== 4'b1000) begin errors++; $display("FAIL midreset_cursor: got %b expected 1000", cursor); end
    checks++; if (editing !== 1'b0) begin errors++; $display("FAIL midreset_editing: got %b expected 0", editing); end
    checks++; if (finish !== 1'b0) begin errors++; $display("FAIL midreset_finish: got %b expected 0", finish); end
    reset = 1'b0;
    wait_cycles(12);
    btn = 5'b0;
    wait_cycles(10);
    chk16("postreset_value", value, 16'h0000);
  endtask

  initial begin
    test_reset();
    test_load_up();
    test_invalid_load();
    test_cursor_down();
    test_bouncy();
    test_commit();
    test_abort();
    test_up_left();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
